// File: rtl/uart_hex_rx_if.sv
// Output bundle of the hex line receiver: last accepted word plus status strobes.
interface uart_hex_rx_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                err;
  logic                busy;

  modport master (output value, value_valid, err, busy);
  modport slave  (input  value, value_valid, err, busy);
endinterface

// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver feeding an ASCII-hex line parser; each terminated line
// of up to DIGITS hex digits is published as one right-aligned binary word.
module uart_hex_rx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  uart_hex_rx_if.master bus
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int unsigned AW    = 4 * DIGITS;
  localparam int unsigned DC_W  = $clog2(DIGITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [DC_W-1:0]  DIG_MAX   = DC_W'(DIGITS);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    P_COLLECT, P_DISCARD
  } p_state_t;

  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shreg, shreg_next;
  logic             rx_meta, rx_s;
  logic             byte_stb_c, frame_err_c;

  p_state_t         p_state, p_next;
  logic [AW-1:0]    acc, acc_next;
  logic [DC_W-1:0]  count, count_next;
  logic [AW-1:0]    value_q, value_next;
  logic             valid_q, valid_next;
  logic             err_q, err_next;
  logic             busy_q;

  // Synchronizer resets to the idle level so a reset never fakes a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      busy_q   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      busy_q   <= (rx_next != RX_IDLE);
    end
  end

  // Receiver next-state: mid-bit sampling, LSB first
  always_comb begin
    rx_next      = rx_state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    byte_stb_c   = 1'b0;
    frame_err_c  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_s) rx_next = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          rx_next      = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next     = '0;
          shreg_next   = {rx_s, shreg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            byte_stb_c = 1'b1;
            rx_next    = RX_IDLE;
          end else begin
            frame_err_c = 1'b1;
            rx_next     = RX_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Returns {is_digit, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] ch);
    hex_decode = '0;
    if (ch >= 8'h30 && ch <= 8'h39)      hex_decode = {1'b1, 4'(ch - 8'h30)};
    else if (ch >= 8'h41 && ch <= 8'h46) hex_decode = {1'b1, 4'(ch - 8'h37)};
    else if (ch >= 8'h61 && ch <= 8'h66) hex_decode = {1'b1, 4'(ch - 8'h57)};
  endfunction

  logic [4:0] dec_c;
  logic       is_term_c, is_space_c;

  assign dec_c      = hex_decode(shreg);
  assign is_term_c  = (shreg == 8'h0A) || (shreg == 8'h0D);
  assign is_space_c = (shreg == 8'h20);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state <= P_COLLECT;
      acc     <= '0;
      count   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      p_state <= p_next;
      acc     <= acc_next;
      count   <= count_next;
      value_q <= value_next;
      valid_q <= valid_next;
      err_q   <= err_next;
    end
  end

  // Line parser: consumes one byte per strobe, a framing error drops the line
  always_comb begin
    p_next     = p_state;
    acc_next   = acc;
    count_next = count;
    value_next = value_q;
    valid_next = 1'b0;
    err_next   = frame_err_c;
    if (frame_err_c) begin
      p_next     = P_DISCARD;
      acc_next   = '0;
      count_next = '0;
    end else if (byte_stb_c) begin
      case (p_state)
        P_COLLECT: begin
          if (is_term_c) begin
            if (count != '0) begin
              value_next = acc;
              valid_next = 1'b1;
            end
            acc_next   = '0;
            count_next = '0;
          end else if (is_space_c) begin
            p_next = P_COLLECT;
          end else if (dec_c[4] && count != DIG_MAX) begin
            acc_next   = {acc[AW-5:0], dec_c[3:0]};
            count_next = count + 1'b1;
          end else begin
            err_next = 1'b1;
            p_next   = P_DISCARD;
          end
        end
        P_DISCARD: begin
          if (is_term_c) begin
            acc_next   = '0;
            count_next = '0;
            p_next     = P_COLLECT;
          end
        end
        default: p_next = P_COLLECT;
      endcase
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;

endmodule
